pipe_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline enable/flush sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int DRAIN_DEPTH_DEF = 3;
  localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline register enable/flush sequencer with HALT drain FSM and
// saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DRAIN_DEPTH = DRAIN_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifetch_stall,
  input  logic             dmem_stall,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             halt_id,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = $clog2(DRAIN_DEPTH + 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [DW-1:0] r_drain_cnt;
  logic [DW-1:0] w_next_cnt;
  logic          w_stall_inc;
  logic          w_flush_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_cnt;
    end
  end

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_flush  = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_drain_cnt;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;

    if (!rst) begin
      case (r_state)
        RUN: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          if (dmem_stall) begin
            {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
            memwb_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (branch_taken) begin
            // Branch is older than any HALT in ID, so HALT is squashed here.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_flush_inc = 1'b1;
          end else if (ifetch_stall) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end else if (halt_id) begin
            pc_en        = 1'b0;
            ifid_flush   = 1'b1;
            w_next_state = DRAIN;
            w_next_cnt   = DW'(DRAIN_DEPTH);
          end
          w_stall_inc = ~pc_en;
        end

        DRAIN: begin
          if (dmem_stall) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
          end else begin
            {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            w_next_cnt = r_drain_cnt - DW'(1);
            if (r_drain_cnt == DW'(1)) begin
              w_next_state = HALTED;
            end
          end
        end

        default: begin
          w_next_state = HALTED;
        end
      endcase
    end
  end

  assign halted = (r_state == HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (4-bit counters so saturation is reachable).
module tb_pipe_ctrl;

  localparam int CW = 4;

  // {pc,ifid,idex,exmem,memwb en, ifid,idex,memwb flush, halted}
  localparam logic [8:0] V_RST    = 9'b00000_000_0;
  localparam logic [8:0] V_IDLE   = 9'b11111_000_0;
  localparam logic [8:0] V_DMEM   = 9'b00001_001_0;
  localparam logic [8:0] V_LU     = 9'b00111_010_0;
  localparam logic [8:0] V_BR     = 9'b11111_110_0;
  localparam logic [8:0] V_IFS    = 9'b01111_100_0;
  localparam logic [8:0] V_DRN    = 9'b01111_110_0;
  localparam logic [8:0] V_HALTED = 9'b00000_000_1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifetch_stall = 1'b0;
  logic          dmem_stall = 1'b0;
  logic          load_use = 1'b0;
  logic          branch_taken = 1'b0;
  logic          halt_id = 1'b0;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, memwb_flush, halted;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [8:0]    obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CW), .DRAIN_DEPTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifetch_stall (ifetch_stall),
    .dmem_stall   (dmem_stall),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .halt_id      (halt_id),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_flush  (memwb_flush),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, memwb_flush, halted};

  // Advance one cycle, drive new inputs just after the edge, settle.
  task automatic step(input logic r, input logic ifs, input logic dm,
                      input logic lu, input logic br, input logic h);
    @(posedge clk);
    #1;
    rst          = r;
    ifetch_stall = ifs;
    dmem_stall   = dm;
    load_use     = lu;
    branch_taken = br;
    halt_id      = h;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
    $display("t=%0t %-12s obs=%0h exp=%0h", $time, tag, o, e);
  endtask

  task automatic check_all(input string tag, input logic [8:0] v,
                           input logic [CW-1:0] sc, input logic [CW-1:0] fc);
    check({tag, "_ctl"}, 32'(obs), 32'(v));
    check({tag, "_stl"}, 32'(stall_cycles), 32'(sc));
    check({tag, "_fls"}, 32'(flush_count), 32'(fc));
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check_all("rst", V_RST, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_all("idle", V_IDLE, 0, 0);

    // load_use single cycle
    step(0, 0, 0, 1, 0, 0);
    check_all("lu", V_LU, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_all("lu_after", V_IDLE, 1, 0);

    // dmem_stall masks branch_taken, then branch alone
    step(0, 0, 1, 0, 1, 0);
    check_all("dm_br1", V_DMEM, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    check_all("dm_br2", V_DMEM, 2, 0);
    step(0, 0, 0, 0, 1, 0);
    check_all("br", V_BR, 3, 0);
    step(0, 0, 0, 0, 0, 0);
    check_all("br_after", V_IDLE, 3, 1);

    // ifetch stall
    step(0, 1, 0, 0, 0, 0);
    check_all("ifs", V_IFS, 3, 1);
    step(0, 0, 0, 0, 0, 0);
    check_all("ifs_after", V_IDLE, 4, 1);

    // HALT squashed by branch: stays in RUN
    step(0, 0, 0, 0, 1, 1);
    check_all("halt_br", V_BR, 4, 1);
    step(0, 0, 0, 0, 0, 0);
    check_all("halt_br_aft", V_IDLE, 4, 2);

    // load_use beats HALT, HALT taken next cycle, dmem in second drain cycle
    step(0, 0, 0, 1, 0, 1);
    check_all("lu_halt", V_LU, 4, 2);
    step(0, 0, 0, 0, 0, 1);
    check_all("halt", V_IFS, 5, 2);
    step(0, 0, 0, 1, 1, 0);
    check_all("drn1", V_DRN, 6, 2);
    step(0, 0, 1, 0, 0, 0);
    check_all("drn_dm", V_DMEM, 6, 2);
    step(0, 0, 0, 0, 0, 0);
    check_all("drn2", V_DRN, 6, 2);
    step(0, 1, 0, 0, 1, 0);
    check_all("drn3", V_DRN, 6, 2);
    step(0, 0, 0, 0, 0, 0);
    check_all("halted", V_HALTED, 6, 2);
    step(0, 1, 1, 1, 1, 1);
    check_all("halted_hold", V_HALTED, 6, 2);

    // Reset out of HALTED
    step(1, 0, 0, 0, 0, 0);
    check("hrst_ctl", 32'(obs[8:1]), 32'(V_RST[8:1]));
    step(0, 0, 0, 0, 0, 0);
    check_all("hrst_after", V_IDLE, 0, 0);

    // Clean HALT: DRAIN three cycles, HALTED on the fourth
    step(0, 0, 0, 0, 0, 1);
    check_all("halt2", V_IFS, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_all("h2_drn1", V_DRN, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check_all("h2_drn2", V_DRN, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check_all("h2_drn3", V_DRN, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check_all("h2_halted", V_HALTED, 1, 0);

    // Reset mid-DRAIN
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check_all("mid_drn", V_DRN, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_all("mid_rst", V_IDLE, 0, 0);

    // Saturation of stall counter
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    check_all("sat", V_IDLE, 15, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_all("sat_hold", V_IDLE, 15, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
